// File: rtl/xbox_xmem_arb.sv
// Request/grant arbiter between NUM_XLRS accelerators and NUM_MEMS XBOX memories:
// per-memory round-robin or fixed priority, tagged read return, saturating stall counters.
module xbox_xmem_arb #(
  parameter int NUM_XLRS           = 4,
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 8,
  parameter int RD_LAT             = 1,
  parameter bit ARB_RR             = 1'b1
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [NUM_XLRS-1:0][NUM_MEMS-1:0]                   xi_req,
  input  logic [NUM_XLRS-1:0][NUM_MEMS-1:0]                   xi_wr,
  input  logic [NUM_XLRS-1:0][NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xi_addr,
  input  logic [NUM_XLRS-1:0][NUM_MEMS-1:0][7:0][31:0]        xi_wdata,
  input  logic [NUM_XLRS-1:0][NUM_MEMS-1:0][31:0]             xi_be,
  output logic [NUM_XLRS-1:0][NUM_MEMS-1:0]                   xi_gnt,
  output logic [NUM_XLRS-1:0][NUM_MEMS-1:0]                   xi_rvalid,
  output logic [NUM_XLRS-1:0][NUM_MEMS-1:0][7:0][31:0]        xi_rdata,
  output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]         xlr_mem_addr,
  output logic [NUM_MEMS-1:0][7:0][31:0]                      xlr_mem_wdata,
  output logic [NUM_MEMS-1:0][31:0]                           xlr_mem_be,
  output logic [NUM_MEMS-1:0]                                 xlr_mem_rd,
  output logic [NUM_MEMS-1:0]                                 xlr_mem_wr,
  input  logic [NUM_MEMS-1:0][7:0][31:0]                      xlr_mem_rdata,
  input  logic                                                stall_clr,
  output logic [NUM_XLRS-1:0][15:0]                           stall_cnt
);
  localparam int PW = (NUM_XLRS > 1) ? $clog2(NUM_XLRS) : 1;

  logic [NUM_MEMS-1:0][PW-1:0]             ptr_q, ptr_d;
  logic [NUM_MEMS-1:0]                     win_vld;
  logic [NUM_MEMS-1:0][PW-1:0]             win_idx;
  logic [PW-1:0]                           cand;
  logic [NUM_MEMS-1:0][RD_LAT-1:0]         tag_vld_q, tag_vld_d;
  logic [NUM_MEMS-1:0][RD_LAT-1:0][PW-1:0] tag_idx_q, tag_idx_d;
  logic [NUM_XLRS-1:0][15:0]               cnt_q, cnt_d;
  logic [NUM_XLRS-1:0]                     stall_any;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_XLRS) s -= NUM_XLRS;
    return PW'(s);
  endfunction

  // Search order starts at the pointer (RR) or at index 0 (fixed); reset blocks all grants.
  always_comb begin
    win_vld = '0;
    win_idx = '0;
    cand    = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      for (int o = 0; o < NUM_XLRS; o++) begin
        cand = ARB_RR ? wrap_add(ptr_q[m], o) : PW'(o);
        if (rst_n && !win_vld[m] && xi_req[cand][m]) begin
          win_vld[m] = 1'b1;
          win_idx[m] = cand;
        end
      end
    end
  end

  always_comb begin
    xi_gnt        = '0;
    xlr_mem_addr  = '0;
    xlr_mem_wdata = '0;
    xlr_mem_be    = '0;
    xlr_mem_rd    = '0;
    xlr_mem_wr    = '0;
    ptr_d         = ptr_q;
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (win_vld[m]) begin
        xi_gnt[win_idx[m]][m] = 1'b1;
        xlr_mem_addr[m]       = xi_addr[win_idx[m]][m];
        xlr_mem_wdata[m]      = xi_wdata[win_idx[m]][m];
        xlr_mem_be[m]         = xi_be[win_idx[m]][m];
        xlr_mem_wr[m]         = xi_wr[win_idx[m]][m];
        xlr_mem_rd[m]         = !xi_wr[win_idx[m]][m];
        if (ARB_RR) ptr_d[m]  = wrap_add(win_idx[m], 1);
      end
    end
  end

  // Tag pipeline mirrors the memory read latency so the tag lines up with rdata.
  always_comb begin
    tag_vld_d = '0;
    tag_idx_d = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      tag_vld_d[m][0] = xlr_mem_rd[m];
      tag_idx_d[m][0] = win_idx[m];
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_d[m][i] = tag_vld_q[m][i-1];
        tag_idx_d[m][i] = tag_idx_q[m][i-1];
      end
    end
  end

  always_comb begin
    xi_rvalid = '0;
    xi_rdata  = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      for (int k = 0; k < NUM_XLRS; k++) begin
        if (tag_vld_q[m][RD_LAT-1] && tag_idx_q[m][RD_LAT-1] == PW'(k)) begin
          xi_rvalid[k][m] = 1'b1;
          xi_rdata[k][m]  = xlr_mem_rdata[m];
        end
      end
    end
  end

  // One increment per cycle however many memories stall the accelerator; clear wins.
  always_comb begin
    stall_any = '0;
    cnt_d     = cnt_q;
    for (int k = 0; k < NUM_XLRS; k++) begin
      stall_any[k] = |(xi_req[k] & ~xi_gnt[k]);
      if (stall_clr)
        cnt_d[k] = '0;
      else if (stall_any[k] && cnt_q[k] != 16'hFFFF)
        cnt_d[k] = cnt_q[k] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_xbox_xmem_arb.sv
// Bench for xbox_xmem_arb: four instances (RR/lat1, RR/lat3, RR/lat2, fixed/lat1) share
// stimulus; read returns are checked by a scoreboard monitor on the instance under test.
module tb_xbox_xmem_arb;
  localparam int NX = 4, NM = 2, AW = 8, NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NX-1:0][NM-1:0]            xi_req, xi_wr;
  logic [NX-1:0][NM-1:0][AW-1:0]    xi_addr;
  logic [NX-1:0][NM-1:0][7:0][31:0] xi_wdata;
  logic [NX-1:0][NM-1:0][31:0]      xi_be;
  logic                             stall_clr;

  logic [NX-1:0][NM-1:0]            gnt    [NI];
  logic [NX-1:0][NM-1:0]            rvalid [NI];
  logic [NX-1:0][NM-1:0][7:0][31:0] rdata  [NI];
  logic [NM-1:0][AW-1:0]            m_addr [NI];
  logic [NM-1:0][7:0][31:0]         m_wdata[NI];
  logic [NM-1:0][31:0]              m_be   [NI];
  logic [NM-1:0]                    m_rd   [NI];
  logic [NM-1:0]                    m_wr   [NI];
  logic [NM-1:0][7:0][31:0]         m_rdata[NI];
  logic [NX-1:0][15:0]              scnt   [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { int k; int m; int cyc; logic [255:0] d; } sb_t;
  sb_t sb_q[$];
  int  act = 0;
  bit  mon_en = 1'b0;

  // Memory content model: 0x10 holds the 0xA5 pattern.
  function automatic logic [255:0] fpat(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {4{a}} ^ 32'hB5B5B5B5;
    return {8{w}};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : (g == 2) ? 2 : 1;
    localparam bit RR  = (g != 3);
    logic [NM-1:0][AW-1:0] apipe [LAT];

    xbox_xmem_arb #(.NUM_XLRS(NX), .NUM_MEMS(NM), .LOG2_LINES_PER_MEM(AW),
                    .RD_LAT(LAT), .ARB_RR(RR)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .xi_req(xi_req), .xi_wr(xi_wr), .xi_addr(xi_addr), .xi_wdata(xi_wdata), .xi_be(xi_be),
      .xi_gnt(gnt[g]), .xi_rvalid(rvalid[g]), .xi_rdata(rdata[g]),
      .xlr_mem_addr(m_addr[g]), .xlr_mem_wdata(m_wdata[g]), .xlr_mem_be(m_be[g]),
      .xlr_mem_rd(m_rd[g]), .xlr_mem_wr(m_wr[g]), .xlr_mem_rdata(m_rdata[g]),
      .stall_clr(stall_clr), .stall_cnt(scnt[g]));

    always @(posedge clk) begin
      apipe[0] <= m_addr[g];
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign m_rdata[g] = {fpat(apipe[LAT-1][1]), fpat(apipe[LAT-1][0])};
  end

  // Scoreboard monitor: entries due this cycle form the only allowed rvalid/rdata.
  logic [NX-1:0][NM-1:0]            mon_ev;
  logic [NX-1:0][NM-1:0][7:0][31:0] mon_ed;
  int  mon_i;
  bit  mon_shown;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_ev = '0;
      mon_ed = '0;
      mon_i  = 0;
      while (mon_i < sb_q.size()) begin
        if (sb_q[mon_i].cyc <= cyc) begin
          mon_ev[sb_q[mon_i].k][sb_q[mon_i].m] = 1'b1;
          mon_ed[sb_q[mon_i].k][sb_q[mon_i].m] = sb_q[mon_i].d;
          sb_q.delete(mon_i);
        end else begin
          mon_i++;
        end
      end
      n_tests++;
      if (rvalid[act] !== mon_ev) begin
        n_fail++;
        $display("FAIL rvalid_route inst%0d cyc%0d: got %b, expected %b", act, cyc, rvalid[act], mon_ev);
      end
      n_tests++;
      if (rdata[act] !== mon_ed) begin
        n_fail++;
        mon_shown = 1'b0;
        for (int k = 0; k < NX; k++)
          for (int m = 0; m < NM; m++)
            if (!mon_shown && rdata[act][k][m] !== mon_ed[k][m]) begin
              mon_shown = 1'b1;
              $display("FAIL rdata_route inst%0d cyc%0d xlr%0d mem%0d: got %h, expected %h",
                       act, cyc, k, m, rdata[act][k][m], mon_ed[k][m]);
            end
      end
    end
  end

  task automatic idle();
    xi_req = '0; xi_wr = '0; xi_addr = '0; xi_wdata = '0; xi_be = '0; stall_clr = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_rd(input int k, input int m, input int lat, input logic [AW-1:0] a);
    sb_t e;
    e.k = k; e.m = m; e.cyc = cyc + lat; e.d = fpat(a);
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    xi_req = '1; xi_wr = '0; xi_addr = '1; xi_wdata = '1; xi_be = '1; stall_clr = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      n_tests++;
      if (gnt[g] !== '0 || m_rd[g] !== '0 || m_wr[g] !== '0 || m_addr[g] !== '0 ||
          m_wdata[g] !== '0 || m_be[g] !== '0 || rvalid[g] !== '0 || rdata[g] !== '0 || scnt[g] !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d: gnt %b rd %b wr %b addr %h be %h rvalid %b stall %h, expected all zero",
                 g, gnt[g], m_rd[g], m_wr[g], m_addr[g], m_be[g], rvalid[g], scnt[g]);
      end
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    logic [NX-1:0][NM-1:0] eg;
    act = 0; mon_en = 1'b1;
    apply_reset();
    xi_req[2][0] = 1'b1; xi_addr[2][0] = 8'h10;
    @(negedge clk);
    eg = '0; eg[2][0] = 1'b1;
    n_tests++;
    if (gnt[0] !== eg) begin
      n_fail++; $display("FAIL single_gnt: got %b, expected %b", gnt[0], eg);
    end
    n_tests++;
    if (m_rd[0] !== 2'b01 || m_wr[0] !== 2'b00 || m_addr[0][0] !== 8'h10) begin
      n_fail++; $display("FAIL single_memport: rd %b wr %b addr %h, expected rd 01 wr 00 addr 10", m_rd[0], m_wr[0], m_addr[0][0]);
    end
    push_rd(2, 0, 1, 8'h10);
    next_cycle();
    idle();
    @(negedge clk);
    n_tests++;
    if (rvalid[0][2][0] !== 1'b1 || rdata[0][2][0] !== {8{32'hA5A5A5A5}}) begin
      n_fail++; $display("FAIL single_rdata: rvalid %b data %h, expected 1 with a5 pattern", rvalid[0][2][0], rdata[0][2][0]);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL single_drain: %0d reads outstanding, expected 0", sb_q.size());
    end
  endtask

  // Each xlr k requests from cycle 0 until its second grant at cycle k+4, so it
  // stalls k+5 cycles minus 2 grants = k+3 cycles.
  task automatic test_rr_fairness();
    logic [NX-1:0][NM-1:0] eg;
    act = 0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < NX; k++) begin
        xi_req[k][0]  = (c <= k + 4);
        xi_addr[k][0] = AW'(8'h20 + k);
      end
      @(negedge clk);
      eg = '0; eg[c % NX][0] = 1'b1;
      n_tests++;
      if (gnt[0] !== eg) begin
        n_fail++; $display("FAIL rr_order cyc%0d: got %b, expected %b", c, gnt[0], eg);
      end
      push_rd(c % NX, 0, 1, AW'(8'h20 + c % NX));
      next_cycle();
    end
    idle();
    @(negedge clk);
    n_tests++;
    if (scnt[0] !== {16'd6, 16'd5, 16'd4, 16'd3}) begin
      n_fail++; $display("FAIL rr_stall: got %h, expected 0006000500040003", scnt[0]);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL rr_drain: %0d reads outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_parallel_mems();
    logic [NX-1:0][NM-1:0] eg;
    logic [255:0] wd;
    act = 0;
    apply_reset();
    wd = {8{32'h1234_5678}};
    xi_req[0][0] = 1'b1; xi_wr[0][0] = 1'b1; xi_addr[0][0] = 8'h33;
    xi_wdata[0][0] = wd; xi_be[0][0] = 32'h0000_000F;
    xi_req[1][1] = 1'b1; xi_wr[1][1] = 1'b0; xi_addr[1][1] = 8'h44;
    @(negedge clk);
    eg = '0; eg[0][0] = 1'b1; eg[1][1] = 1'b1;
    n_tests++;
    if (gnt[0] !== eg) begin
      n_fail++; $display("FAIL par_gnt: got %b, expected %b", gnt[0], eg);
    end
    n_tests++;
    if (m_wr[0] !== 2'b01 || m_rd[0] !== 2'b10 || m_be[0][0] !== 32'h0000_000F ||
        m_wdata[0][0] !== wd || m_addr[0][1] !== 8'h44) begin
      n_fail++; $display("FAIL par_memport: wr %b rd %b be %h addr1 %h, expected wr 01 rd 10 be 0000000f addr1 44",
                         m_wr[0], m_rd[0], m_be[0][0], m_addr[0][1]);
    end
    push_rd(1, 1, 1, 8'h44);
    next_cycle();
    idle();
    repeat (3) next_cycle();
    @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL par_drain: %0d reads outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_pipelined();
    logic [NX-1:0][NM-1:0] eg;
    act = 1;
    apply_reset();
    for (int s = 0; s < 7; s++) begin
      idle();
      eg = '0;
      case (s)
        0: begin xi_req[0][1] = 1'b1; xi_addr[0][1] = 8'h50; eg[0][1] = 1'b1; end
        1: begin xi_req[3][1] = 1'b1; xi_addr[3][1] = 8'h53; eg[3][1] = 1'b1; end
        2: begin xi_req[2][1] = 1'b1; xi_wr[2][1] = 1'b1; xi_addr[2][1] = 8'h5A; eg[2][1] = 1'b1; end
        default: ;
      endcase
      @(negedge clk);
      n_tests++;
      if (gnt[1] !== eg) begin
        n_fail++; $display("FAIL pipe_gnt step%0d: got %b, expected %b", s, gnt[1], eg);
      end
      if (s == 0) push_rd(0, 1, 3, 8'h50);
      if (s == 1) push_rd(3, 1, 3, 8'h53);
      if (s == 5) begin
        n_tests++;
        if (rvalid[1] !== '0) begin
          n_fail++; $display("FAIL pipe_no_rvalid_t5: got %b, expected 0", rvalid[1]);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL pipe_drain: %0d reads outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    logic [NX-1:0][NM-1:0] eg;
    int seen;
    act = 2;
    apply_reset();
    xi_req[2][0] = 1'b1; xi_addr[2][0] = 8'h10;
    @(negedge clk);
    eg = '0; eg[2][0] = 1'b1;
    n_tests++;
    if (gnt[2] !== eg) begin
      n_fail++; $display("FAIL rst_pre_gnt: got %b, expected %b", gnt[2], eg);
    end
    next_cycle();
    rst_n = 1'b0;
    for (int k = 0; k < NX; k++) begin
      xi_req[k][0] = 1'b1; xi_addr[k][0] = AW'(k + 1); xi_be[k][0] = '1;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if (gnt[2] !== '0 || m_rd[2] !== '0 || m_wr[2] !== '0 || m_addr[2] !== '0 || m_be[2] !== '0 ||
          m_wdata[2] !== '0 || rvalid[2] !== '0 || rdata[2] !== '0 || scnt[2] !== '0) begin
        n_fail++; $display("FAIL rst_mid_outputs cyc%0d: gnt %b rd %b addr %h rvalid %b stall %h, expected all zero",
                           c, gnt[2], m_rd[2], m_addr[2], rvalid[2], scnt[2]);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    for (int k = 0; k < NX; k++) xi_wr[k][0] = 1'b1;
    @(negedge clk);
    eg = '0; eg[0][0] = 1'b1;
    n_tests++;
    if (gnt[2] !== eg) begin
      n_fail++; $display("FAIL rst_ptr_restart: got %b, expected %b", gnt[2], eg);
    end
    next_cycle();
    idle();
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rvalid[2] !== '0) seen++;
      next_cycle();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_stale_rvalid: %0d cycles with rvalid, expected 0", seen);
    end
  endtask

  task automatic test_fixed_priority();
    logic [NX-1:0][NM-1:0] eg;
    int bad;
    logic [15:0] at100, at_sat;
    act = 3;
    apply_reset();
    xi_req[1][1] = 1'b1; xi_wr[1][1] = 1'b1; xi_addr[1][1] = 8'h61;
    xi_req[3][1] = 1'b1; xi_wr[3][1] = 1'b1; xi_addr[3][1] = 8'h63;
    eg = '0; eg[1][1] = 1'b1;
    bad = 0; at100 = '0; at_sat = '0;
    for (int c = 0; c < 65540; c++) begin
      @(negedge clk);
      if (gnt[3] !== eg) bad++;
      if (c == 100)   at100  = scnt[3][3];
      if (c == 65535) at_sat = scnt[3][3];
      next_cycle();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL fp_gnt: %0d cycles without the xlr1-only grant, expected 0", bad);
    end
    n_tests++;
    if (at100 !== 16'd100) begin
      n_fail++; $display("FAIL fp_stall_count: got %0d at cycle 100, expected 100", at100);
    end
    n_tests++;
    if (at_sat !== 16'hFFFF) begin
      n_fail++; $display("FAIL fp_stall_reach: got %h at cycle 65535, expected ffff", at_sat);
    end
    stall_clr = 1'b1;
    @(negedge clk);
    n_tests++;
    if (scnt[3][3] !== 16'hFFFF || scnt[3][1] !== 16'h0) begin
      n_fail++; $display("FAIL fp_stall_sat: xlr3 %h xlr1 %h, expected ffff and 0000", scnt[3][3], scnt[3][1]);
    end
    next_cycle();
    stall_clr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (scnt[3][3] !== 16'h0) begin
      n_fail++; $display("FAIL fp_clr_wins: got %h, expected 0000", scnt[3][3]);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (scnt[3][3] !== 16'h1) begin
      n_fail++; $display("FAIL fp_count_after_clr: got %h, expected 0001", scnt[3][3]);
    end
    next_cycle();
    idle();
    for (int k = 0; k < NX; k++) begin xi_req[k][0] = 1'b1; xi_wr[k][0] = 1'b1; end
    eg = '0; eg[0][0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if (gnt[3] !== eg) begin
        n_fail++; $display("FAIL fp_lowest_wins cyc%0d: got %b, expected %b", c, gnt[3], eg);
      end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_rr_fairness();
    test_parallel_mems();
    test_pipelined();
    test_reset_mid_read();
    test_fixed_priority();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
